mem_access_unit: RTL and testbench

Memory-stage access controller: the consumer side of the EX/MEM pipeline register. It takes the latched ALU result (address), store data and control bits, drives a handshaked data memory with variable latency, and stalls the upstream pipeline until the access completes. It then presents the write-back value and destination to the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/dff.sv | 20 ++
 rtl/sat_counter.sv | 34 +++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int REG_ADDR_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/dff.sv
// Generic register cell with write enable and synchronous active-high reset to zero.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    dff #(.W(W)) u_count (
        .clk (clk),
        .rst (rst),
        .wen (1'b1),
        .d   (count_d),
        .q   (count_q)
    );

    assign count = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues one handshaked memory access per load/store,
// stalls upstream until it completes or times out, then hands the result to MEM/WB.
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     MALU_Out,
    input  logic [DATA_W-1:0]     MALU_In2,
    input  logic                  MemWrite,
    input  logic                  MemToReg,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] RegAddr,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic                  stall,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_RegWrite,
    output logic [REG_ADDR_W-1:0] wb_RegAddr,
    output logic                  mem_err,
    output logic [15:0]           stall_cycles
);

    localparam int WAIT_CNT_W = $clog2(WAIT_MAX + 1);

    mem_state_t            state_d;
    mem_state_t            state_q;
    logic [1:0]            state_bits;
    logic                  is_store_d;
    logic                  is_store_q;
    logic                  reg_write_d;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] reg_addr_d;
    logic [REG_ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0]     addr_d;
    logic [DATA_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_d;
    logic [DATA_W-1:0]     data_q;
    logic                  access;
    logic                  issue;
    logic                  in_wait;
    logic                  timeout;
    logic                  leave_wait;
    logic                  capture;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    assign state_q = mem_state_t'(state_bits);

    // Counter is bumped on issue so it reads 1 in the first WAIT cycle.
    always_comb begin
        access      = MemWrite | MemToReg;
        issue       = (state_q == IDLE) && access;
        in_wait     = (state_q == WAIT);
        timeout     = in_wait && !mem_valid && (wait_cnt == WAIT_CNT_W'(WAIT_MAX));
        leave_wait  = in_wait && (mem_valid || timeout);
        capture     = (in_wait && mem_valid && !is_store_q) || timeout;
        data_d      = timeout ? '0 : mem_rdata;
        is_store_d  = MemWrite;
        reg_write_d = RegWrite;
        reg_addr_d  = RegAddr;
        addr_d      = MALU_Out;

        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = WAIT;
            WAIT:    if (leave_wait) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        stall       = 1'b0;
        mem_err     = 1'b0;
        wb_data     = MALU_Out;
        wb_RegWrite = 1'b0;
        wb_RegAddr  = RegAddr;
        case (state_q)
            IDLE: begin
                if (access) begin
                    mem_enable = 1'b1;
                    mem_wr     = MemWrite;
                    mem_addr   = MALU_Out;
                    mem_wdata  = MALU_In2;
                    stall      = 1'b1;
                end else begin
                    wb_RegWrite = RegWrite;
                end
            end
            WAIT: begin
                stall      = 1'b1;
                mem_err    = timeout;
                wb_RegAddr = reg_addr_q;
            end
            DONE: begin
                wb_data     = is_store_q ? addr_q : data_q;
                wb_RegWrite = reg_write_q & ~is_store_q;
                wb_RegAddr  = reg_addr_q;
            end
            default: ;
        endcase
    end

    dff #(.W(2)) u_state (
        .clk (clk), .rst (rst), .wen (1'b1), .d (state_d), .q (state_bits)
    );

    dff #(.W(1)) u_is_store (
        .clk (clk), .rst (rst), .wen (issue), .d (is_store_d), .q (is_store_q)
    );

    dff #(.W(1)) u_reg_write (
        .clk (clk), .rst (rst), .wen (issue), .d (reg_write_d), .q (reg_write_q)
    );

    dff #(.W(REG_ADDR_W)) u_reg_addr (
        .clk (clk), .rst (rst), .wen (issue), .d (reg_addr_d), .q (reg_addr_q)
    );

    dff #(.W(DATA_W)) u_addr (
        .clk (clk), .rst (rst), .wen (issue), .d (addr_d), .q (addr_q)
    );

    dff #(.W(DATA_W)) u_data (
        .clk (clk), .rst (rst), .wen (capture), .d (data_d), .q (data_q)
    );

    sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (leave_wait),
        .inc   (issue | in_wait),
        .count (wait_cnt)
    );

    sat_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions, a latency-programmable
// memory model, and a retire monitor that checks each MEM/WB hand-off.
module tb_mem_access_unit;

    localparam int DW   = 16;
    localparam int WMAX = 15;

    typedef struct {
        logic [15:0] data;
        logic        rw;
        logic [3:0]  ra;
        int          stalls;
        int          err;
    } wb_exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
    } req_t;

    typedef struct {
        logic        mw;
        logic        mr;
        logic        rw;
        logic [3:0]  ra;
        logic [15:0] alu;
        logic [15:0] sd;
        int          lat;
        logic [15:0] rdata;
        logic [15:0] exp_data;
        logic        exp_rw;
        int          exp_stalls;
        int          exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] MALU_Out;
    logic [DW-1:0] MALU_In2;
    logic          MemWrite;
    logic          MemToReg;
    logic          RegWrite;
    logic [3:0]    RegAddr;
    logic          mem_enable;
    logic          mem_wr;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          stall;
    logic [DW-1:0] wb_data;
    logic          wb_RegWrite;
    logic [3:0]    wb_RegAddr;
    logic          mem_err;
    logic [15:0]   stall_cycles;

    wb_exp_t wb_exp[$];
    req_t    req_exp[$];
    int      req_cyc[$];
    vec_t    vecs[$];
    int      exp_sc[$];
    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;

    mem_access_unit #(.DATA_W(DW), .WAIT_MAX(WMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .MALU_Out     (MALU_Out),
        .MALU_In2     (MALU_In2),
        .MemWrite     (MemWrite),
        .MemToReg     (MemToReg),
        .RegWrite     (RegWrite),
        .RegAddr      (RegAddr),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .stall        (stall),
        .wb_data      (wb_data),
        .wb_RegWrite  (wb_RegWrite),
        .wb_RegAddr   (wb_RegAddr),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic mw, input logic mr, input logic rw,
                                   input logic [3:0] ra, input logic [15:0] alu,
                                   input logic [15:0] sd, input int lat,
                                   input logic [15:0] rdata, input logic [15:0] exp_data,
                                   input logic exp_rw, input int exp_stalls, input int exp_err);
        vec_t v;
        v.mw = mw; v.mr = mr; v.rw = rw; v.ra = ra; v.alu = alu; v.sd = sd;
        v.lat = lat; v.rdata = rdata; v.exp_data = exp_data; v.exp_rw = exp_rw;
        v.exp_stalls = exp_stalls; v.exp_err = exp_err;
        return v;
    endfunction

    // Holds one instruction in EX/MEM until the DUT stops stalling, queueing its expectations.
    task automatic applyStimulus(input vec_t v);
        wb_exp_t e;
        req_t    r;
        int      n;
        MemWrite = v.mw;
        MemToReg = v.mr;
        RegWrite = v.rw;
        RegAddr  = v.ra;
        MALU_Out = v.alu;
        MALU_In2 = v.sd;
        e.data = v.exp_data; e.rw = v.exp_rw; e.ra = v.ra;
        e.stalls = v.exp_stalls; e.err = v.exp_err;
        wb_exp.push_back(e);
        if (v.mw || v.mr) begin
            r.wr = v.mw; r.addr = v.alu; r.wdata = v.sd; r.lat = v.lat; r.rdata = v.rdata;
            req_exp.push_back(r);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 40);
        if (stall) checkOutput("retire_timeout", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each request after its programmed latency.
    initial begin
        req_t r;
        mem_valid = 1'b0;
        mem_rdata = 16'h5A5A;
        forever begin
            @(negedge clk);
            if (mem_enable === 1'b1 && rst === 1'b0) begin
                if (req_exp.size() == 0) begin
                    checkOutput("spurious_req", 32'(mem_enable), 32'd0);
                end else begin
                    r = req_exp.pop_front();
                    req_cyc.push_back(cyc);
                    checkOutput("req_wr", 32'(mem_wr), 32'(r.wr));
                    checkOutput("req_addr", 32'(mem_addr), 32'(r.addr));
                    checkOutput("req_wdata", 32'(mem_wdata), 32'(r.wdata));
                    repeat (r.lat) @(posedge clk);
                    #1;
                    mem_valid = 1'b1;
                    mem_rdata = r.rdata;
                    @(posedge clk);
                    #1;
                    mem_valid = 1'b0;
                    mem_rdata = 16'h5A5A;
                end
            end
        end
    end

    // Retire monitor: each stall=0 cycle hands one instruction to MEM/WB.
    initial begin
        wb_exp_t e;
        int stall_run = 0;
        int err_pos   = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                stall_run = 0;
                err_pos   = 0;
            end else if (stall) begin
                stall_run++;
                if (mem_err) err_pos = stall_run;
                checkOutput("rw_during_stall", 32'(wb_RegWrite), 32'd0);
            end else begin
                if (mem_err) err_pos = -1;
                if (wb_exp.size() == 0) begin
                    checkOutput("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = wb_exp.pop_front();
                    checkOutput("wb_data", 32'(wb_data), 32'(e.data));
                    checkOutput("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
                    checkOutput("wb_RegAddr", 32'(wb_RegAddr), 32'(e.ra));
                    checkOutput("stall_len", 32'(stall_run), 32'(e.stalls));
                    checkOutput("err_pos", 32'(err_pos), 32'(e.err));
                end
                stall_run = 0;
                err_pos   = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t nop;
        rst = 1'b1;
        MemWrite = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0; RegAddr = 4'd0;
        MALU_Out = '0; MALU_In2 = '0;

        //                mw    mr    rw    ra     alu       sd        lat rdata     exp_data  exp_rw stalls err
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 16'h0000, 0,  16'h0000, 16'h0000, 1'b0, 0,  0));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'd5,  16'h1234, 16'h0000, 0,  16'h0000, 16'h1234, 1'b1, 0,  0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'd3,  16'h0040, 16'h0000, 3,  16'hBEEF, 16'hBEEF, 1'b1, 4,  0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 4'd7,  16'h0080, 16'hA5A5, 1,  16'h0000, 16'h0080, 1'b0, 2,  0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'd9,  16'h00C0, 16'h1111, 2,  16'h0000, 16'h00C0, 1'b0, 3,  0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'd2,  16'h0100, 16'h0000, 18, 16'h7777, 16'h0000, 1'b1, 16, 16));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'd1,  16'h0F0F, 16'h0000, 0,  16'h0000, 16'h0F0F, 1'b1, 0,  0));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 4'd15, 16'hFFFF, 16'h0000, 0,  16'h0000, 16'hFFFF, 1'b0, 0,  0));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'd14, 16'h0001, 16'h0000, 0,  16'h0000, 16'h0001, 1'b1, 0,  0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'd4,  16'h0200, 16'h0000, 1,  16'h1357, 16'h1357, 1'b1, 2,  0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'd6,  16'h0202, 16'h0000, 1,  16'h2468, 16'h2468, 1'b1, 2,  0));
        exp_sc = '{0, 0, 4, 6, 9, 25, 25, 25, 25, 27, 29};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mem_enable", 32'(mem_enable), 32'd0);
        checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
        checkOutput("rst_wb_RegAddr", 32'(wb_RegAddr), 32'd0);
        checkOutput("rst_wb_data", 32'(wb_data), 32'd0);
        checkOutput("rst_stall_cycles", 32'(stall_cycles), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput("stall_cycles", 32'(stall_cycles), 32'(exp_sc[i]));
        end
        checkOutput("b2b_gap", 32'(req_cyc[req_cyc.size()-1] - req_cyc[req_cyc.size()-2]), 32'd3);

        // Load whose response (6 cycles out) is overtaken by a reset in WAIT.
        MemWrite = 1'b0; MemToReg = 1'b1; RegWrite = 1'b1; RegAddr = 4'd8;
        MALU_Out = 16'h0300; MALU_In2 = 16'h0000;
        begin
            req_t r;
            r.wr = 1'b0; r.addr = 16'h0300; r.wdata = 16'h0000; r.lat = 6; r.rdata = 16'hDEAD;
            req_exp.push_back(r);
        end
        @(posedge clk);
        #1;
        checkOutput("wait_stall", 32'(stall), 32'd1);
        checkOutput("wait_mem_enable", 32'(mem_enable), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        MemToReg = 1'b0; RegWrite = 1'b0; RegAddr = 4'd0; MALU_Out = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post_rst_stall", 32'(stall), 32'd0);
        checkOutput("post_rst_mem_enable", 32'(mem_enable), 32'd0);
        checkOutput("post_rst_stall_cycles", 32'(stall_cycles), 32'd0);

        nop = mkVec(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0, 0, 0);
        repeat (6) applyStimulus(nop);
        applyStimulus(mkVec(1'b0, 1'b0, 1'b1, 4'd10, 16'h4321, 16'h0000, 0, 16'h0000, 16'h4321, 1'b1, 0, 0));
        checkOutput("final_stall_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("wb_queue_empty", 32'(wb_exp.size()), 32'd0);
        checkOutput("req_queue_empty", 32'(req_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
